// File: rtl/bp_pkg.sv
// Shared definitions for the gshare branch predictor: default history width,
// the 2-bit saturating counter type, its named states and the saturating
// update function.
package bp_pkg;

  localparam int unsigned HIST_W_DEF = 8;

  typedef logic [1:0] ctr_t;

  localparam ctr_t SNT = 2'd0;  // strongly not-taken
  localparam ctr_t WNT = 2'd1;  // weakly not-taken
  localparam ctr_t WT  = 2'd2;  // weakly taken
  localparam ctr_t ST  = 2'd3;  // strongly taken

  // Saturating update: taken counts up to ST, not-taken counts down to SNT.
  function automatic ctr_t ctr_next(ctr_t c, logic taken);
    ctr_t r;
    r = c;
    if (taken) begin
      if (c != ST) r = c + 2'd1;
    end else begin
      if (c != SNT) r = c - 2'd1;
    end
    return r;
  endfunction

endpackage

// File: rtl/bp_stats.sv
// Resolved-branch statistics for the branch predictor.
// Ports:
//   clk, rst            - clock, asynchronous active-high reset
//   update_valid        - one resolved branch this cycle
//   update_mispredict   - that branch was mispredicted
//   stat_branches       - resolved branch count (wraps modulo 2^32)
//   stat_misses         - misprediction count (wraps modulo 2^32)
module bp_stats (
  input  logic        clk,
  input  logic        rst,
  input  logic        update_valid,
  input  logic        update_mispredict,
  output logic [31:0] stat_branches,
  output logic [31:0] stat_misses
);

  logic [31:0] branches_q, branches_d;
  logic [31:0] misses_q,   misses_d;

  always_comb begin
    branches_d = branches_q;
    misses_d   = misses_q;
    if (update_valid) begin
      branches_d = branches_q + 32'd1;
      if (update_mispredict) misses_d = misses_q + 32'd1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      branches_q <= '0;
      misses_q   <= '0;
    end else begin
      branches_q <= branches_d;
      misses_q   <= misses_d;
    end
  end

  assign stat_branches = branches_q;
  assign stat_misses   = misses_q;

endmodule

// File: rtl/branch_predictor.sv
// Gshare direction predictor for the fetch stage.
// The lookup index is lookup_pc[HIST_W+1:2] ^ ghr (combinational); the
// prediction for that index is registered and appears one cycle later.
// Execute trains the 2-bit counter table and shifts the non-speculative
// global history with each resolved branch.
// Ports:
//   clk, rst               - clock, asynchronous active-high reset
//   lookup_pc              - fetch instruction-memory read address
//   pc_xor_global_history  - lookup index (combinational)
//   prediction             - taken prediction for last cycle's lookup
//   update_valid/index/taken/mispredict - resolved branch from execute
//   stat_branches/misses   - statistics counters
// Configuration: define BP_STATS_EN to build the statistics counters;
// otherwise the stat outputs are tied to zero.
module branch_predictor
  import bp_pkg::*;
#(
  parameter int unsigned HIST_W   = HIST_W_DEF,
  parameter ctr_t        CTR_INIT = WNT
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [31:0]       lookup_pc,
  output logic [HIST_W-1:0] pc_xor_global_history,
  output logic              prediction,
  input  logic              update_valid,
  input  logic [HIST_W-1:0] update_index,
  input  logic              update_taken,
  input  logic              update_mispredict,
  output logic [31:0]       stat_branches,
  output logic [31:0]       stat_misses
);

  localparam int unsigned DEPTH = 1 << HIST_W;

  logic [HIST_W-1:0] ghr_q, ghr_d;
  logic [HIST_W-1:0] idx_q, idx_d;
  logic              pred_q, pred_d;
  ctr_t              ctr_q [DEPTH];
  ctr_t              ctr_d [DEPTH];
  logic [HIST_W-1:0] lookup_idx;

  assign lookup_idx            = lookup_pc[HIST_W+1:2] ^ ghr_q;
  assign pc_xor_global_history = lookup_idx;
  assign prediction            = pred_q;

  always_comb begin
    ctr_d = ctr_q;
    ghr_d = ghr_q;
    if (update_valid) begin
      ctr_d[update_index] = ctr_next(ctr_q[update_index], update_taken);
      ghr_d               = {ghr_q[HIST_W-2:0], update_taken};
    end
    idx_d  = lookup_idx;
    // Reading the post-update table gives the same-cycle write bypass.
    pred_d = ctr_d[lookup_idx][1];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ghr_q  <= '0;
      idx_q  <= '0;
      pred_q <= 1'b0;
      for (int unsigned i = 0; i < DEPTH; i++) ctr_q[i] <= CTR_INIT;
    end else begin
      ghr_q  <= ghr_d;
      idx_q  <= idx_d;
      pred_q <= pred_d;
      for (int unsigned i = 0; i < DEPTH; i++) ctr_q[i] <= ctr_d[i];
    end
  end

`ifdef BP_STATS_EN
  bp_stats u_stats (
    .clk              (clk),
    .rst              (rst),
    .update_valid     (update_valid),
    .update_mispredict(update_mispredict),
    .stat_branches    (stat_branches),
    .stat_misses      (stat_misses)
  );
`else
  assign stat_branches = '0;
  assign stat_misses   = '0;
`endif

  // idx_q is carried state with no consumer inside this block; the other
  // bits are address bits outside the hash.
  logic unused_bits;
  assign unused_bits = ^{lookup_pc[31:HIST_W+2], lookup_pc[1:0], idx_q,
                         update_mispredict};

endmodule

// File: tb/tb_branch_predictor.sv
module tb_branch_predictor;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [31:0] lookup_pc = 32'h0;
  logic [7:0]  pc_xor_global_history;
  logic        prediction;
  logic        update_valid = 1'b0;
  logic [7:0]  update_index = 8'h0;
  logic        update_taken = 1'b0;
  logic        update_mispredict = 1'b0;
  logic [31:0] stat_branches;
  logic [31:0] stat_misses;

  int passed = 0;
  int total  = 0;

  always #5 clk = ~clk;

  branch_predictor #(.HIST_W(8), .CTR_INIT(2'b01)) dut (
    .clk                  (clk),
    .rst                  (rst),
    .lookup_pc            (lookup_pc),
    .pc_xor_global_history(pc_xor_global_history),
    .prediction           (prediction),
    .update_valid         (update_valid),
    .update_index         (update_index),
    .update_taken         (update_taken),
    .update_mispredict    (update_mispredict),
    .stat_branches        (stat_branches),
    .stat_misses          (stat_misses)
  );

  typedef struct {
    logic [31:0] pc;
    logic        uv;
    logic [7:0]  ui;
    logic        ut;
    logic        um;
    logic [7:0]  exp_idx;
    logic        exp_pred;
  } vec_t;

  vec_t vec [16];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
  endtask

  // Drive one cycle at the falling edge, check the index before the rising
  // edge and the registered prediction just after it.
  task automatic apply(input vec_t v, input string name);
    lookup_pc         = v.pc;
    update_valid      = v.uv;
    update_index      = v.ui;
    update_taken      = v.ut;
    update_mispredict = v.um;
    #1;
    check({name, " idx"}, {24'h0, pc_xor_global_history}, {24'h0, v.exp_idx});
    @(posedge clk);
    #1;
    check({name, " pred"}, {31'h0, prediction}, {31'h0, v.exp_pred});
    @(negedge clk);
    update_valid      = 1'b0;
    update_mispredict = 1'b0;
  endtask

  initial begin
    logic [31:0] exp_b, exp_m;
    // pc, valid, index, taken, misp, exp_idx, exp_pred  (ghr noted after)
    vec[0]  = '{32'h040, 1'b0, 8'h00, 1'b0, 1'b0, 8'h10, 1'b0}; // ghr 00
    vec[1]  = '{32'h040, 1'b1, 8'h10, 1'b1, 1'b0, 8'h10, 1'b1}; // 01->10 bypass, ghr 01
    vec[2]  = '{32'h040, 1'b1, 8'h10, 1'b1, 1'b1, 8'h11, 1'b0}; // 10->11, ghr 03
    vec[3]  = '{32'h040, 1'b1, 8'h10, 1'b1, 1'b0, 8'h13, 1'b0}; // 11 sat, ghr 07
    vec[4]  = '{32'h040, 1'b0, 8'h00, 1'b0, 1'b0, 8'h17, 1'b0};
    vec[5]  = '{32'h05C, 1'b0, 8'h00, 1'b0, 1'b0, 8'h10, 1'b1}; // ctr[10]=11
    vec[6]  = '{32'h05C, 1'b1, 8'h10, 1'b0, 1'b0, 8'h10, 1'b1}; // 11->10, ghr 0E
    vec[7]  = '{32'h078, 1'b1, 8'h10, 1'b0, 1'b1, 8'h10, 1'b0}; // 10->01, ghr 1C
    vec[8]  = '{32'h030, 1'b0, 8'h00, 1'b0, 1'b0, 8'h10, 1'b0}; // 01 reads 0
    vec[9]  = '{32'h030, 1'b1, 8'h10, 1'b0, 1'b0, 8'h10, 1'b0}; // 01->00, ghr 38
    vec[10] = '{32'h0A0, 1'b1, 8'h10, 1'b0, 1'b0, 8'h10, 1'b0}; // 00 sat, ghr 70
    vec[11] = '{32'h180, 1'b1, 8'h10, 1'b1, 1'b0, 8'h10, 1'b0}; // 00->01, ghr E1
    vec[12] = '{32'h3C4, 1'b1, 8'h10, 1'b1, 1'b0, 8'h10, 1'b1}; // collision 01->10, ghr C3
    vec[13] = '{32'h38C, 1'b1, 8'h55, 1'b1, 1'b0, 8'h20, 1'b0}; // other index, ghr 87
    vec[14] = '{32'h348, 1'b0, 8'h00, 1'b0, 1'b0, 8'h55, 1'b1}; // ctr[55]=10
    vec[15] = '{32'h348, 1'b0, 8'h00, 1'b0, 1'b0, 8'h55, 1'b1}; // stall: stable

    // Reset state
    lookup_pc = 32'h40;
    #2;
    check("rst pred", {31'h0, prediction}, 32'h0);
    check("rst idx", {24'h0, pc_xor_global_history}, 32'h10);
    check("rst stat_branches", stat_branches, 32'h0);
    check("rst stat_misses", stat_misses, 32'h0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;

    for (int i = 0; i < 16; i++) apply(vec[i], $sformatf("vec%0d", i));

`ifdef BP_STATS_EN
    exp_b = 32'd10; exp_m = 32'd2;
`else
    exp_b = 32'd0;  exp_m = 32'd0;
`endif
    check("train stat_branches", stat_branches, exp_b);
    check("train stat_misses", stat_misses, exp_m);

    // Asynchronous reset mid-cycle (clock high, no edge pending for 2 ns)
    @(posedge clk);
    #2;
    check("pre-rst pred", {31'h0, prediction}, 32'h1);
    rst = 1'b1;
    #1;
    check("async rst pred", {31'h0, prediction}, 32'h0);
    check("async rst idx", {24'h0, pc_xor_global_history}, 32'hD2);
    check("async rst stat_branches", stat_branches, 32'h0);
    check("async rst stat_misses", stat_misses, 32'h0);
    @(negedge clk);
    rst = 1'b0;

    // Trained entries read back as CTR_INIT after reset
    apply('{32'h154, 1'b0, 8'h00, 1'b0, 1'b0, 8'h55, 1'b0}, "post-rst 55");
    apply('{32'h040, 1'b0, 8'h00, 1'b0, 1'b0, 8'h10, 1'b0}, "post-rst 10");

    // Statistics: 5 updates, 2 mispredicted; a flagged non-update is ignored
    apply('{32'h000, 1'b1, 8'h00, 1'b1, 1'b1, 8'h00, 1'b1}, "st0"); // 01->10, ghr 01
    apply('{32'h000, 1'b1, 8'h00, 1'b1, 1'b0, 8'h01, 1'b0}, "st1"); // ctr[00]=11, ghr 03
    apply('{32'h000, 1'b0, 8'h00, 1'b0, 1'b1, 8'h03, 1'b0}, "st2");
    apply('{32'h000, 1'b1, 8'h00, 1'b0, 1'b0, 8'h03, 1'b0}, "st3"); // 11->10, ghr 06
    apply('{32'h000, 1'b1, 8'h00, 1'b0, 1'b1, 8'h06, 1'b0}, "st4"); // 10->01, ghr 0C
    apply('{32'h030, 1'b1, 8'h00, 1'b0, 1'b0, 8'h00, 1'b0}, "st5"); // 01->00 bypass, ghr 18
`ifdef BP_STATS_EN
    exp_b = 32'd5; exp_m = 32'd2;
`else
    exp_b = 32'd0; exp_m = 32'd0;
`endif
    check("stat_branches", stat_branches, exp_b);
    check("stat_misses", stat_misses, exp_m);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/branch_predictor.md
# branch_predictor

Gshare direction predictor paired with the fetch stage. Each cycle it takes fetch's instruction-memory read address and hashes it with the global history into a table index. Fetch receives that index combinationally, and the taken/not-taken prediction one cycle later, in step with the returned instruction word. Execute later returns the carried index and the resolved outcome, which train the table and the history.

## Interface
Parameters:
- `HIST_W`, 8: history length and table index width; table depth is 2^HIST_W.
- `CTR_INIT`, 2'b01: reset value of every 2-bit counter (weakly not-taken).

Ports:
- `clk`, in, 1: the single clock.
- `rst`, in, 1: asynchronous, active-high reset.
- `lookup_pc`, in, 32: fetch's current instruction-memory read address.
- `pc_xor_global_history`, out, HIST_W: lookup index, `lookup_pc[HIST_W+1:2] ^ ghr`, combinational.
- `prediction`, out, 1: taken prediction for the address presented on the previous cycle; registered.
- `update_valid`, in, 1: one resolved conditional branch this cycle.
- `update_index`, in, HIST_W: the index carried down the pipe with that branch.
- `update_taken`, in, 1: resolved direction.
- `update_mispredict`, in, 1: resolved direction differed from the prediction; used for statistics only.
- `stat_branches`, out, 32: count of resolved branches.
- `stat_misses`, out, 32: count of mispredictions.

## Operation
- State:
  - `ghr` (HIST_W bits).
  - Counter array `ctr[2^HIST_W]`, 2 bits each, implemented as flops so the asynchronous reset can clear it.
  - Index register `idx_q`.
  - Prediction register `pred_q`.
- Lookup, every cycle with no enable:
  - `pc_xor_global_history = lookup_pc[HIST_W+1:2] ^ ghr`, using the current (pre-update) `ghr`.
  - On the clock edge, `idx_q` captures that index.
  - `pred_q` captures bit 1 of the counter at the captured index, after bypassing any same-cycle update to that index.
- Stalls: fetch holds its address steady, so the lookup repeats and `prediction` stays stable unless training changes the entry.
- Training, when `update_valid`=1:
  - `ctr[update_index]` saturates: taken increments, stopping at 3; not-taken decrements, stopping at 0.
  - `ghr <= {ghr[HIST_W-2:0], update_taken}`.
- When `update_valid`=0, counters and `ghr` hold.
- History is non-speculative: only resolved branches shift it. Non-branch instructions and jal never call for an update.
- Read/write collision: if the lookup index equals `update_index` in the same cycle, `pred_q` takes the post-update counter's bit 1.
- Unknown or non-branch instruction words still produce a prediction; fetch ignores it.

## Timing
- Index latency: 0 cycles (combinational from `lookup_pc` and `ghr`).
- Prediction latency: 1 cycle. `prediction` at cycle t+1 corresponds to `lookup_pc` at cycle t.
- Training latency:
  - A counter written at edge t affects lookups captured at edge t or later (bypass).
  - A `ghr` shift at edge t affects the combinational index from cycle t+1 on.
- Reset, asynchronous, while `rst`=1:
  - `ghr` = 0; every `ctr` = `CTR_INIT`.
  - `idx_q` = 0; `pred_q` = 0 (`prediction` = 0).
  - Statistics = 0.
  - `pc_xor_global_history = lookup_pc[HIST_W+1:2]`.
- Reset asserted mid-operation discards all training. The first edge after deassertion behaves as a fresh lookup.
- Updates arrive at most one per cycle; no handshake and no backpressure.

## Configuration
- `BP_STATS_EN` defined:
  - `stat_branches` increments on every `update_valid`.
  - `stat_misses` increments when `update_valid && update_mispredict`.
  - Both counters wrap modulo 2^32.
- Not defined: both counter flops are compiled out and both outputs are tied to 0. Port list is unchanged.

## Structure
- Shared package `bp_pkg`:
  - `HIST_W` default.
  - `ctr_t` (2-bit) typedef.
  - Counter constants SNT=0, WNT=1, WT=2, ST=3.
  - Function `ctr_next(ctr_t c, logic taken)` implementing saturation.
- One natural sub-module, `bp_stats`: the two 32-bit statistics counters, instantiated only under `BP_STATS_EN`.

## Test plan
- Reset, then `lookup_pc`=0x0000_0040 → `pc_xor_global_history`=0x10 immediately; `prediction`=0 the next cycle.
- Three updates, index 0x10, taken → counter 01→10→11→11 (saturates). `ghr` = 0b111; index for pc 0x40 becomes 0x17.
- Pre-load the counter at index 0x10 to 11, then two not-taken updates → counter 01. A lookup of index 0x10 then gives `prediction`=0.
- Same-cycle collision: counter at 0x10 = 01, lookup index 0x10, and update taken to 0x10 → `prediction`=1 on the next cycle.
- Assert `rst` asynchronously after training, mid-cycle → all outputs return to reset values at once, without waiting for a `clk` edge. Subsequent lookups read `CTR_INIT`.
- With `BP_STATS_EN`: 5 updates, 2 flagged mispredict → `stat_branches`=5, `stat_misses`=2. Without the macro, both outputs read 0.
